// File: rtl/bcd_seg_display.sv
// bcd_seg_display: captures a bcd_adder result {carry, digit} and shows it on a
// two-digit multiplexed 7-segment display (ones and tens), with a minimum hold
// time per result and an error indication for out-of-range values.
//
// Optional build macro: BCD_SEG_BLANK_EN
//   defined   -> leading-zero blanking of the tens digit
//   undefined -> tens digit shows 0 when the result is below 10
module bcd_seg_display #(
  parameter int unsigned SCAN_DIV = 4,  // cycles per digit before the scan advances (2..65535)
  parameter int unsigned HOLD_CYC = 8   // minimum display cycles per result (1..65535)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [4:0] res,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  // FSM encoding
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHOW = 1'b1;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);

  // Segment patterns (seg[6]=a .. seg[0]=g)
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_E     = 7'b1001111;

  logic [0:0]  state_q, state_d;
  logic [4:0]  res_q, res_d;
  logic        err_q, err_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] scan_q, scan_d;
  logic        sel_q, sel_d;     // 0 = ones digit, 1 = tens digit
  logic [6:0]  seg_q, seg_d;
  logic [1:0]  an_q, an_d;

  logic        xfer;
  logic        tens_d;
  logic [4:0]  ones_raw;
  logic [3:0]  ones_d;

  // Decimal digit to active-high segment pattern
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'b1111110;
      4'd1:    c = 7'b0110000;
      4'd2:    c = 7'b1101101;
      4'd3:    c = 7'b1111001;
      4'd4:    c = 7'b0110011;
      4'd5:    c = 7'b1011011;
      4'd6:    c = 7'b1011111;
      4'd7:    c = 7'b1110000;
      4'd8:    c = 7'b1111111;
      4'd9:    c = 7'b1111011;
      default: c = SEG_BLANK;
    endcase
    return c;
  endfunction

  // Ready whenever idle, or once the hold time of the shown result has elapsed
  assign in_ready = (state_q == IDLE) || (hold_q == 16'd0);
  assign xfer     = in_valid && in_ready;

  // Next-state logic: hold countdown, digit scan and result capture
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    err_d   = err_q;
    hold_d  = hold_q;
    scan_d  = scan_q;
    sel_d   = sel_q;

    if (state_q == SHOW) begin
      if (hold_q != 16'd0) begin
        hold_d = hold_q - 16'd1;
      end
      if (scan_q == SCAN_LAST) begin
        scan_d = 16'd0;
        sel_d  = ~sel_q;
      end else begin
        scan_d = scan_q + 16'd1;
      end
    end

    if (xfer) begin
      res_d   = res;
      err_d   = (res > 5'd19);
      hold_d  = HOLD_LOAD;
      state_d = SHOW;
      // Only a fresh start from IDLE restarts the scan; a reload keeps the phase
      if (state_q == IDLE) begin
        scan_d = 16'd0;
        sel_d  = 1'b0;
      end
    end
  end

  // Digit split of the next result; only meaningful when err_d is clear
  always_comb begin
    tens_d   = (res_d >= 5'd10);
    ones_raw = tens_d ? (res_d - 5'd10) : res_d;
    ones_d   = ones_raw[3:0];
  end

  // Output decode from next state so the registered an/seg track sel_q exactly
  always_comb begin
    an_d  = 2'b00;
    seg_d = SEG_BLANK;
    if (state_d == SHOW) begin
      if (sel_d) begin
        an_d = 2'b10;
        if (err_d) begin
          seg_d = SEG_BLANK;
        end else if (tens_d) begin
          seg_d = seg_code(4'd1);
        end else begin
`ifdef BCD_SEG_BLANK_EN
          seg_d = SEG_BLANK;
`else
          seg_d = seg_code(4'd0);
`endif
        end
      end else begin
        an_d  = 2'b01;
        seg_d = err_d ? SEG_E : seg_code(ones_d);
      end
    end
  end

  // State registers with synchronous reset; reset wins over a concurrent transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= 5'd0;
      err_q   <= 1'b0;
      hold_q  <= 16'd0;
      scan_q  <= 16'd0;
      sel_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      an_q    <= 2'b00;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      err_q   <= err_d;
      hold_q  <= hold_d;
      scan_q  <= scan_d;
      sel_q   <= sel_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign err = err_q;

  // Both digit drivers must never be enabled together
  a_an_onehot0 : assert property (@(posedge clk) an != 2'b11);

endmodule

// File: tb/tb_bcd_seg_display.sv
// Self-checking bench for bcd_seg_display (SCAN_DIV=4, HOLD_CYC=8).
// Each accepted result pushes its expected display into a scoreboard queue;
// the scenario pops it and compares every displayed cycle.
module tb_bcd_seg_display;

  localparam int SD = 4;
  localparam int HC = 8;

  typedef struct packed {
    logic [6:0] ones;
    logic [6:0] tens;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] res;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int   tests;
  int   fails;
  int   ph;        // cycles since the display left IDLE
  bit   showing;
  exp_t sb[$];
  exp_t cur;
  logic [1:0] exp_an;
  logic [6:0] exp_sg;

  bcd_seg_display #(.SCAN_DIV(SD), .HOLD_CYC(HC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .res      (res),
    .seg      (seg),
    .an       (an),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] code(input int d);
    case (d)
      0: return 7'b1111110;
      1: return 7'b0110000;
      2: return 7'b1101101;
      3: return 7'b1111001;
      4: return 7'b0110011;
      5: return 7'b1011011;
      6: return 7'b1011111;
      7: return 7'b1110000;
      8: return 7'b1111111;
      9: return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  function automatic exp_t model(input int r);
    exp_t e;
    if (r >= 20) begin
      e.ones = 7'b1001111;
      e.tens = 7'b0000000;
      e.err  = 1'b1;
    end else begin
      e.ones = code(r % 10);
`ifdef BCD_SEG_BLANK_EN
      e.tens = (r >= 10) ? code(1) : 7'b0000000;
`else
      e.tens = code(r / 10);
`endif
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ph++;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    res      = 5'd0;
    tick();
    tick();
    rst     = 1'b0;
    showing = 1'b0;
    sb.delete();
  endtask

  // Waits (bounded) for in_ready, transfers r, pushes its expected display
  task automatic xfer(input int r);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL xfer_ready_timeout res=%0d in_ready=%b required 1", r, in_ready);
    end
    in_valid = 1'b1;
    res      = 5'(r);
    tick();
    in_valid = 1'b0;
    if (!showing) begin
      ph      = 0;
      showing = 1'b1;
    end
    sb.push_back(model(r));
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 10; k++) begin
      tests++;
      if (an !== 2'b00 || seg !== 7'b0000000 || err !== 1'b0 || in_ready !== 1'b1) begin
        fails++;
        $display("FAIL reset k=%0d an=%b seg=%b err=%b rdy=%b required an=00 seg=0000000 err=0 rdy=1",
                 k, an, seg, err, in_ready);
      end
      tick();
    end
  endtask

  // Shows the popped result for n cycles; checks scan phase, segments, err and ready
  task automatic test_display(input string name, input int r, input int n);
    xfer(r);
    cur = sb.pop_front();
    for (int k = 0; k < n; k++) begin
      exp_an = ((ph / SD) % 2 == 1) ? 2'b10 : 2'b01;
      exp_sg = ((ph / SD) % 2 == 1) ? cur.tens : cur.ones;
      tests++;
      if (an !== exp_an || seg !== exp_sg || err !== cur.err || in_ready !== (k >= HC - 1)) begin
        fails++;
        $display("FAIL %s k=%0d an=%b seg=%b err=%b rdy=%b required an=%b seg=%b err=%b rdy=%b",
                 name, k, an, seg, err, in_ready, exp_an, exp_sg, cur.err, (k >= HC - 1));
      end
      if (k != n - 1) tick();
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_t nxt;
    do_reset();
    in_valid = 1'b1;
    res      = 5'd9;
    tick();
    ph      = 0;
    showing = 1'b1;
    sb.push_back(model(9));
    res = 5'd18;  // held while not ready
    cur = sb.pop_front();
    for (int k = 0; k < HC; k++) begin
      exp_an = ((ph / SD) % 2 == 1) ? 2'b10 : 2'b01;
      exp_sg = ((ph / SD) % 2 == 1) ? cur.tens : cur.ones;
      tests++;
      if (an !== exp_an || seg !== exp_sg || in_ready !== (k == HC - 1)) begin
        fails++;
        $display("FAIL b2b_hold k=%0d an=%b seg=%b rdy=%b required an=%b seg=%b rdy=%b",
                 k, an, seg, in_ready, exp_an, exp_sg, (k == HC - 1));
      end
      tick();
    end
    // 18 accepted on the edge that closed the loop above; phase keeps running
    in_valid = 1'b0;
    sb.push_back(model(18));
    nxt = sb.pop_front();
    for (int k = 0; k < 2 * SD; k++) begin
      exp_an = ((ph / SD) % 2 == 1) ? 2'b10 : 2'b01;
      exp_sg = ((ph / SD) % 2 == 1) ? nxt.tens : nxt.ones;
      tests++;
      if (an !== exp_an || seg !== exp_sg || err !== 1'b0) begin
        fails++;
        $display("FAIL b2b_second ph=%0d an=%b seg=%b err=%b required an=%b seg=%b err=0",
                 ph, an, seg, err, exp_an, exp_sg);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_show();
    do_reset();
    xfer(25);
    cur = sb.pop_front();
    tick();
    tick();
    tick();
    tests++;
    if (err !== cur.err) begin
      fails++;
      $display("FAIL mid_err_before err=%b required %b", err, cur.err);
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    res      = 5'd12;
    tick();
    tests++;
    if (an !== 2'b00 || seg !== 7'b0000000 || err !== 1'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset an=%b seg=%b err=%b rdy=%b required an=00 seg=0000000 err=0 rdy=1",
               an, seg, err, in_ready);
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    showing  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++;
      if (an !== 2'b00 || seg !== 7'b0000000 || err !== 1'b0) begin
        fails++;
        $display("FAIL mid_after k=%0d an=%b seg=%b err=%b required an=00 seg=0000000 err=0",
                 k, an, seg, err);
      end
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    ph       = 0;
    showing  = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    res      = 5'd0;
    test_reset();
    test_display("scan_5", 5, 16);
    test_display("val_13", 13, 16);
    test_display("err_23", 23, 8);
    test_display("clr_3", 3, 8);
    test_display("val_19", 19, 8);
    test_display("val_0", 0, 8);
    test_back_to_back();
    test_reset_mid_show();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
